// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, FSM encoding and baud divisor
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;
  localparam logic LINE_IDLE = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int baud_divisor(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - byte handshake between register block and TX serializer
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - synchronous byte FIFO with level, empty and full flags
module uart_byte_fifo #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [7:0]          wdata,
  input  logic                pop,
  output logic [7:0]          rdata,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];
  assign empty   = (count == '0);
  assign full    = (count == FULL_LEVEL);
  assign level   = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - buffers bytes and serializes them as 8N1 frames on uart_txd
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ        = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_tx_serializer_if.slave      bus,
  output logic                     uart_txd,
  output logic                     tx_busy,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level
);

  localparam int DIVISOR = baud_divisor(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W   = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic [1:0]           state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] head;
  logic                 line_q;
  logic                 push;
  logic                 pop;
  logic                 bit_end;

  assign bus.in_ready = !fifo_full && !reset;
  assign push         = bus.in_valid && bus.in_ready;
  assign bit_end      = (baud_cnt == CNT_LAST);
  assign tx_busy      = (state != ST_IDLE);

  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE: pop = !fifo_empty;
      ST_STOP: pop = bit_end && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  uart_byte_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus.in_data),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // line_q is the FSM's bit decision; uart_txd re-registers it so the line starts one edge after the pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      line_q   <= LINE_IDLE;
      uart_txd <= LINE_IDLE;
    end else begin
      uart_txd <= line_q;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg    <= head;
            line_q   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            line_q   <= shreg[0];
            shreg    <= shreg >> 1;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              line_q <= 1'b1;
              state  <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              line_q  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg   <= head;
              line_q  <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - two serializer instances checked against a frame-level reference model
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       txd_a, busy_a, empty_a, full_a;
  logic       txd_b, busy_b, empty_b, full_b;
  logic [2:0] level_a;
  logic [5:0] level_b;

  uart_tx_serializer_if if_a();
  uart_tx_serializer_if if_b();

  uart_tx_serializer #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .FIFO_DEPTH_LOG2(2)) dut_a (
    .clk(clk), .reset(rst_a), .bus(if_a.slave), .uart_txd(txd_a), .tx_busy(busy_a),
    .fifo_empty(empty_a), .fifo_full(full_a), .fifo_level(level_a));

  uart_tx_serializer #(.CLK_FREQ(1000000), .BAUD_RATE(300000), .FIFO_DEPTH_LOG2(5)) dut_b (
    .clk(clk), .reset(rst_b), .bus(if_b.slave), .uart_txd(txd_b), .tx_busy(busy_b),
    .fifo_empty(empty_b), .fifo_full(full_b), .fifo_level(level_b));

  int checks = 0;
  int failures = 0;

  // Reference model: a byte queue plus "cycles of frame left", line level by arithmetic.
  int div_m[2]   = '{10, 3};
  int depth_m[2] = '{4, 32};
  int buf_m[2][64];
  int head_m[2], cnt_m[2], busy_m[2], cur_m[2], line_m[2], txd_m[2];
  bit acc_m[2];

  function automatic int frame_bit(input int b, input int idx);
    if (idx == 0) return 0;
    if (idx >= 9) return 1;
    return (b >> (idx - 1)) & 1;
  endfunction

  task automatic model_step(input int i, input bit rst, input bit vld, input int data);
    bit pop_now;
    if (rst) begin
      head_m[i] = 0; cnt_m[i] = 0; busy_m[i] = 0;
      line_m[i] = 1; txd_m[i] = 1; acc_m[i] = 0;
    end else begin
      acc_m[i] = vld && (cnt_m[i] < depth_m[i]);
      pop_now  = (busy_m[i] <= 1) && (cnt_m[i] > 0);
      txd_m[i] = line_m[i];
      if (pop_now) begin
        cur_m[i]  = buf_m[i][head_m[i]];
        head_m[i] = (head_m[i] + 1) % 64;
        cnt_m[i]  = cnt_m[i] - 1;
        busy_m[i] = 10 * div_m[i];
      end else if (busy_m[i] > 0) begin
        busy_m[i] = busy_m[i] - 1;
      end
      if (acc_m[i]) begin
        buf_m[i][(head_m[i] + cnt_m[i]) % 64] = data;
        cnt_m[i] = cnt_m[i] + 1;
      end
      line_m[i] = (busy_m[i] > 0) ?
                  frame_bit(cur_m[i], (10 * div_m[i] - busy_m[i]) / div_m[i]) : 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, rst_a, if_a.in_valid, int'(if_a.in_data));
    model_step(1, rst_b, if_b.in_valid, int'(if_b.in_data));
    @(negedge clk);
    check("a_txd",   32'(txd_a),   32'(txd_m[0]));
    check("a_busy",  32'(busy_a),  32'(busy_m[0] > 0));
    check("a_level", 32'(level_a), 32'(cnt_m[0]));
    check("a_empty", 32'(empty_a), 32'(cnt_m[0] == 0));
    check("a_full",  32'(full_a),  32'(cnt_m[0] == depth_m[0]));
    check("a_ready", 32'(if_a.in_ready), 32'(cnt_m[0] < depth_m[0] && !rst_a));
    check("b_txd",   32'(txd_b),   32'(txd_m[1]));
    check("b_busy",  32'(busy_b),  32'(busy_m[1] > 0));
    check("b_level", 32'(level_b), 32'(cnt_m[1]));
    check("b_empty", 32'(empty_b), 32'(cnt_m[1] == 0));
    check("b_full",  32'(full_b),  32'(cnt_m[1] == depth_m[1]));
    check("b_ready", 32'(if_b.in_ready), 32'(cnt_m[1] < depth_m[1] && !rst_b));
  endtask

  task automatic push_a(input logic [7:0] d);
    int n;
    if_a.in_data = d; if_a.in_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!acc_m[0] && n < 2000);
    if_a.in_valid = 1'b0;
    if (!acc_m[0]) begin failures++; $error("FAIL push_a_timeout observed=0 expected=1"); end
  endtask

  task automatic push_b(input logic [7:0] d);
    int n;
    if_b.in_data = d; if_b.in_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!acc_m[1] && n < 2000);
    if_b.in_valid = 1'b0;
    if (!acc_m[1]) begin failures++; $error("FAIL push_b_timeout observed=0 expected=1"); end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy_m[0] == 0 && cnt_m[0] == 0 && busy_m[1] == 0 && cnt_m[1] == 0) && n < 5000) begin
      tick(); n++;
    end
    if (n >= 5000) begin failures++; $error("FAIL idle_timeout observed=busy expected=idle"); end
    repeat (3) tick();
  endtask

  logic [9:0] pat_a5 = 10'b1101001010;
  logic [9:0] pat_01 = 10'b1000000010;

  initial begin
    for (int i = 0; i < 2; i++) begin
      head_m[i] = 0; cnt_m[i] = 0; busy_m[i] = 0; cur_m[i] = 0;
      line_m[i] = 1; txd_m[i] = 1; acc_m[i] = 0;
    end
    rst_a = 1'b1; rst_b = 1'b1;
    if_a.in_valid = 1'b0; if_a.in_data = 8'h00;
    if_b.in_valid = 1'b0; if_b.in_data = 8'h00;
    repeat (3) tick();
    check("reset_txd_a", 32'(txd_a), 32'd1);
    check("reset_level_a", 32'(level_a), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) tick();

    // Single 0xA5 frame, sampled mid-bit.
    push_a(8'hA5);
    repeat (6) tick();
    for (int k = 0; k < 10; k++) begin
      check("a5_bit", 32'(txd_a), 32'(pat_a5[k]));
      repeat (10) tick();
    end
    wait_idle();
    check("a5_idle_busy", 32'(busy_a), 32'd0);

    // Back-to-back frames.
    push_a(8'h00);
    push_a(8'hFF);
    push_a(8'h55);
    wait_idle();

    // Fill the 4-entry FIFO with continuous valid; the sixth waits for a pop.
    for (int k = 0; k < 6; k++) push_a(8'($urandom));
    wait_idle();

    // Reset during data bit 3 with two bytes queued.
    push_a(8'h3C);
    push_a(8'($urandom));
    push_a(8'($urandom));
    repeat (44) tick();
    rst_a = 1'b1;
    tick();
    check("midreset_txd", 32'(txd_a), 32'd1);
    check("midreset_level", 32'(level_a), 32'd0);
    rst_a = 1'b0;
    repeat (30) tick();
    check("post_reset_txd", 32'(txd_a), 32'd1);

    // Divisor truncation: 1 MHz / 300 kbaud -> 3 cycles per bit.
    push_b(8'h01);
    repeat (3) tick();
    for (int k = 0; k < 10; k++) begin
      check("b01_bit", 32'(txd_b), 32'(pat_01[k]));
      repeat (3) tick();
    end
    wait_idle();

    // Random traffic with random gaps on both instances.
    for (int k = 0; k < 25; k++) begin
      push_a(8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
      push_b(8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
